// File: rtl/fma_pkg.sv
// fma_pkg: shared widths, state encoding and result-word bit positions for the dot8 engine
package fma_pkg;
  localparam int N_LANES = 8;
  localparam int OP_W = 8;
  localparam int ACC_W = 19;
  localparam int VALID_BIT = 31;
  localparam int BUSY_BIT = 30;
  localparam int SUM_MSB = 18;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
endpackage

// File: rtl/fma_dot8_engine_mac8.sv
// fma_mac8: registered unsigned multiply-add into an accumulator with clear and enable
module fma_mac8 #(
  parameter int OP_W = fma_pkg::OP_W,
  parameter int ACC_W = fma_pkg::ACC_W
) (
  input logic clk,
  input logic rst,
  input logic clr,
  input logic en,
  input logic [OP_W-1:0] a,
  input logic [OP_W-1:0] b,
  output logic [ACC_W-1:0] acc
);
  logic [2*OP_W-1:0] prod;
  assign prod = a * b;
  always_ff @(posedge clk) acc <= (rst || clr) ? '0 : en ? acc + ACC_W'(prod) : acc;
endmodule

// File: rtl/fma_dot8_engine.sv
// fma_dot8_engine: snapshot-based sequential 8-lane unsigned dot product with busy/valid status word
module fma_dot8_engine #(
  parameter int N_LANES = fma_pkg::N_LANES,
  parameter int OP_W = fma_pkg::OP_W,
  parameter int ACC_W = fma_pkg::ACC_W
) (
  input logic clk_clk,
  input logic reset_reset,
  input logic [OP_W-1:0] a_0_in,
  input logic [OP_W-1:0] a_1_in,
  input logic [OP_W-1:0] a_2_in,
  input logic [OP_W-1:0] a_3_in,
  input logic [OP_W-1:0] a_4_in,
  input logic [OP_W-1:0] a_5_in,
  input logic [OP_W-1:0] a_6_in,
  input logic [OP_W-1:0] a_7_in,
  input logic [OP_W-1:0] b_0_in,
  input logic [OP_W-1:0] b_1_in,
  input logic [OP_W-1:0] b_2_in,
  input logic [OP_W-1:0] b_3_in,
  input logic [OP_W-1:0] b_4_in,
  input logic [OP_W-1:0] b_5_in,
  input logic [OP_W-1:0] b_6_in,
  input logic [OP_W-1:0] b_7_in,
  output logic [31:0] out_0_result
);
  import fma_pkg::*;
  localparam int IDX_W = $clog2(N_LANES);
  state_t state, state_nxt;
  logic [N_LANES*OP_W-1:0] live_a, live_b, snap_a, snap_b;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] acc;
  logic force_flag, match, start, busy_nxt, valid_nxt;
  assign live_a = {a_7_in, a_6_in, a_5_in, a_4_in, a_3_in, a_2_in, a_1_in, a_0_in};
  assign live_b = {b_7_in, b_6_in, b_5_in, b_4_in, b_3_in, b_2_in, b_1_in, b_0_in};
  assign match = (live_a == snap_a) && (live_b == snap_b);
  assign start = (state == IDLE) && (!match || force_flag);
  fma_mac8 #(.OP_W(OP_W), .ACC_W(ACC_W)) u_mac (
    .clk(clk_clk),
    .rst(reset_reset),
    .clr(start),
    .en(state == MAC),
    .a(snap_a[idx*OP_W +: OP_W]),
    .b(snap_b[idx*OP_W +: OP_W]),
    .acc(acc)
  );
  always_comb begin
    state_nxt = state == IDLE ? (start ? MAC : IDLE) :
                state == MAC ? (idx == IDX_W'(N_LANES - 1) ? DONE : MAC) : IDLE;
    busy_nxt = state_nxt != IDLE;
    valid_nxt = state == DONE ? match : match && out_0_result[VALID_BIT];
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= IDLE;
      idx <= '0;
      snap_a <= '0;
      snap_b <= '0;
      out_0_result <= '0;
      force_flag <= 1'b1;
    end else begin
      state <= state_nxt;
      idx <= state == MAC ? idx + 1'b1 : '0;
      snap_a <= start ? live_a : snap_a;
      snap_b <= start ? live_b : snap_b;
      force_flag <= start ? 1'b0 : force_flag;
      out_0_result[VALID_BIT] <= valid_nxt;
      out_0_result[BUSY_BIT] <= busy_nxt;
      out_0_result[BUSY_BIT-1:SUM_MSB+1] <= '0;
      out_0_result[SUM_MSB:0] <= state == DONE ? acc : out_0_result[SUM_MSB:0];
    end
  end
endmodule

// File: tb/tb_fma_dot8_engine.sv
// tb_fma_dot8_engine: directed and random scoreboard bench for the dot8 engine
module tb_fma_dot8_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] a [8];
  logic [7:0] b [8];
  logic [31:0] out;
  logic [31:0] sb [$];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  fma_dot8_engine dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .a_0_in(a[0]),
    .a_1_in(a[1]),
    .a_2_in(a[2]),
    .a_3_in(a[3]),
    .a_4_in(a[4]),
    .a_5_in(a[5]),
    .a_6_in(a[6]),
    .a_7_in(a[7]),
    .b_0_in(b[0]),
    .b_1_in(b[1]),
    .b_2_in(b[2]),
    .b_3_in(b[3]),
    .b_4_in(b[4]),
    .b_5_in(b[5]),
    .b_6_in(b[6]),
    .b_7_in(b[7]),
    .out_0_result(out)
  );
  function automatic logic [31:0] model(input bit v);
    logic [18:0] s = '0;
    for (int i = 0; i < 8; i++) s += 19'(a[i]) * 19'(b[i]);
    return {v, 1'b0, 11'b0, s};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask
  task automatic pass(input string tag);
    sb.push_back(model(1'b1));
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, {30'b0, out[31:30]}, 32'h1);
    end
    @(negedge clk);
    check(tag, out, sb.pop_front());
  endtask
  task automatic mid_pass(input string tag, input int k, input int lane, input logic [7:0] nb);
    sb.push_back(model(1'b0));
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == k) b[lane] = nb;
      check({tag, "_busy"}, {30'b0, out[31:30]}, 32'h1);
    end
    @(negedge clk);
    check(tag, out, sb.pop_front());
  endtask
  initial begin
    for (int i = 0; i < 8; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset", out, 32'h0);
    rst = 1'b0;
    pass("rst_zero");
    check("rst_zero_lit", out, 32'h8000_0000);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a[i] = 8'd1;
      b[i] = 8'd1;
    end
    pass("ones");
    check("ones_lit", out, 32'h8000_0008);
    for (int i = 0; i < 8; i++) begin
      a[i] = 8'd255;
      b[i] = 8'd255;
    end
    pass("max");
    check("max_lit", out, 32'h8007_F008);
    for (int i = 0; i < 8; i++) begin
      a[i] = 8'(i);
      b[i] = 8'd2;
    end
    pass("ramp");
    check("ramp_lit", out, 32'h8000_0038);
    b[3] = 8'd7;
    pass("ramp_b3_7");
    b[3] = 8'd2;
    mid_pass("ramp_mid", 4, 3, 8'd0);
    check("ramp_mid_lit", out, 32'h0000_0038);
    pass("ramp_b3_0");
    check("ramp_b3_0_lit", out, 32'h8000_0032);
    for (int i = 0; i < 8; i++) begin
      a[i] = 8'(i + 1);
      b[i] = 8'd3;
    end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("pre_rst_busy", {30'b0, out[31:30]}, 32'h1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid", out, 32'h0);
    rst = 1'b0;
    pass("after_rst");
    check("after_rst_lit", out, 32'h8000_006C);
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 8; i++) begin
        a[i] = 8'($urandom);
        b[i] = 8'($urandom);
      end
      a[0] = a[0] ^ 8'($urandom_range(1, 255));
      if (n % 4 == 3) begin
        int lane;
        lane = $urandom_range(0, 7);
        mid_pass("rnd_mid", $urandom_range(1, 8), lane, b[lane] ^ 8'($urandom_range(1, 255)));
      end
      pass("rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
